// File: rtl/conv_mem_fsm.sv
// Memory sequencer between the GPIO control block and the 3x3 convolution unit:
// loads pixels into three column banks, sweeps them into conv, then serves results.
module conv_mem_fsm #(
  parameter int ADDR_W  = 10,
  parameter int N_BANKS = 3,
  parameter int MIN_LEN = 3
) (
  input  logic               i_CLK,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_run,
  input  logic               i_valid,
  input  logic [ADDR_W-1:0]  i_imgLength,
  input  logic               i_res_valid,
  output logic [N_BANKS-1:0] o_we,
  output logic [ADDR_W-1:0]  o_waddr,
  output logic [ADDR_W-1:0]  o_raddr,
  output logic               o_conv_valid,
  output logic               o_out_we,
  output logic [ADDR_W-1:0]  o_out_waddr,
  output logic [ADDR_W-1:0]  o_out_raddr,
  output logic               o_data_valid,
  output logic               o_EOP,
  output logic               o_err,
  output logic [1:0]         dbg_state
);

  localparam int BANK_W = $clog2(N_BANKS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] row;
  logic [BANK_W-1:0] bank;
  logic [ADDR_W-1:0] rescnt;
  logic [ADDR_W-1:0] rdptr;
  logic              issue;
  logic              rd_pend;

  logic              start_load, start_run, err_set;
  logic              wr_fire, res_fire, rd_fire;
  logic              load_done;
  logic [ADDR_W-1:0] len_m1, len_m2, len_m3, rescnt_inc;

  assign load_done  = (bank == BANK_W'(N_BANKS));
  assign len_m1     = len - ADDR_W'(1);
  assign len_m2     = len - ADDR_W'(2);
  assign len_m3     = len - ADDR_W'(3);
  assign rescnt_inc = rescnt + ADDR_W'(1);
  assign dbg_state  = state;

  // i_valid / i_res_valid are single-cycle strobes with no back-pressure: a strobe
  // sampled on a rising edge is acted on at that edge, its effect visible next cycle.
  // A state transition takes priority over any strobe sampled in the same cycle.
  always_comb begin
    state_next = state;
    start_load = 1'b0;
    start_run  = 1'b0;
    err_set    = 1'b0;
    wr_fire    = 1'b0;
    res_fire   = 1'b0;
    rd_fire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_load) begin
          if (i_imgLength >= ADDR_W'(MIN_LEN)) begin
            state_next = S_LOAD;
            start_load = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (i_run) begin
          if (load_done) begin
            state_next = S_RUN;
            start_run  = 1'b1;
          end else begin
            state_next = S_IDLE;
            err_set    = 1'b1;
          end
        end else if (i_valid) begin
          if (load_done) err_set = 1'b1;
          else           wr_fire = 1'b1;
        end
      end
      S_RUN: begin
        if (i_res_valid) begin
          res_fire = 1'b1;
          if (rescnt_inc == len_m2) state_next = S_OUT;
        end
      end
      S_OUT: begin
        if (i_load) begin
          state_next = S_LOAD;
          start_load = 1'b1;
        end else if (i_valid) begin
          rd_fire = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_rst) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge i_CLK or negedge i_rst) begin
    if (!i_rst) begin
      len          <= '0;
      row          <= '0;
      bank         <= '0;
      rescnt       <= '0;
      rdptr        <= '0;
      issue        <= 1'b0;
      rd_pend      <= 1'b0;
      o_we         <= '0;
      o_waddr      <= '0;
      o_raddr      <= '0;
      o_conv_valid <= 1'b0;
      o_out_we     <= 1'b0;
      o_out_waddr  <= '0;
      o_out_raddr  <= '0;
      o_data_valid <= 1'b0;
      o_EOP        <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_we         <= '0;
      o_out_we     <= 1'b0;
      o_data_valid <= rd_pend;
      rd_pend      <= 1'b0;
      o_conv_valid <= issue;

      if (err_set) o_err <= 1'b1;

      if (wr_fire) begin
        o_we    <= N_BANKS'(1) << bank;
        o_waddr <= row;
        if (row == len_m1) begin
          row  <= '0;
          bank <= bank + BANK_W'(1);
        end else begin
          row <= row + ADDR_W'(1);
        end
      end

      // Read sweep: one address per cycle, conv_valid trails by the BRAM latency.
      if (start_run) begin
        o_raddr <= '0;
        issue   <= 1'b1;
      end else if (issue) begin
        if (o_raddr == len_m1) issue   <= 1'b0;
        else                   o_raddr <= o_raddr + ADDR_W'(1);
      end

      if (res_fire) begin
        o_out_we    <= 1'b1;
        o_out_waddr <= rescnt;
        rescnt      <= rescnt_inc;
        if (rescnt_inc == len_m2) o_EOP <= 1'b1;
      end

      // Output bank holds L-2 results, so the read pointer wraps after L-3.
      if (rd_fire) begin
        o_out_raddr <= rdptr;
        rdptr       <= (rdptr == len_m3) ? '0 : rdptr + ADDR_W'(1);
        rd_pend     <= 1'b1;
      end

      if (start_load) begin
        if (state == S_IDLE) len <= i_imgLength;
        row          <= '0;
        bank         <= '0;
        rescnt       <= '0;
        rdptr        <= '0;
        issue        <= 1'b0;
        rd_pend      <= 1'b0;
        o_we         <= '0;
        o_waddr      <= '0;
        o_raddr      <= '0;
        o_conv_valid <= 1'b0;
        o_out_we     <= 1'b0;
        o_out_waddr  <= '0;
        o_out_raddr  <= '0;
        o_data_valid <= 1'b0;
        o_EOP        <= 1'b0;
      end
    end
  end

endmodule
